// File: rtl/pc_generator.sv
// pc_generator: fetch-stage PC source.
// Holds the architectural fetch PC, offers it to fetch over valid/ready,
// and arbitrates a set of prioritised redirect channels (channel 0 wins).
// A misaligned redirect target is aligned down, raises a one-cycle
// misalign pulse and parks the generator in HALT until an aligned redirect.
module pc_generator #(
    parameter int XLEN       = 64,
    parameter int NREDIR     = 3,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int INST_BYTES = 4,
    localparam int SRC_W     = (NREDIR > 1) ? $clog2(NREDIR) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREDIR-1:0]      redir_valid,
    input  logic [NREDIR*XLEN-1:0] redir_pc,
    input  logic                   halt,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [XLEN-1:0]        req_pc,
    output logic                   redir_taken,
    output logic [SRC_W-1:0]       redir_src,
    output logic                   misalign
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    // Low address bits that must be zero for an aligned instruction fetch.
    localparam logic [XLEN-1:0] OFFSET_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_INC      = XLEN'(INST_BYTES);

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic              misalign_pend_q;
    logic              misalign_pend_d;

    logic              redir_any;
    logic [SRC_W-1:0]  winner;
    logic [XLEN-1:0]   winner_pc;
    logic              target_misaligned;
    logic [XLEN-1:0]   target_aligned;
    logic              handshake;

    // Priority pick of the redirect channels: scanning from the top down
    // leaves the lowest requesting index as the winner.
    always_comb begin
        redir_any = 1'b0;
        winner    = '0;
        winner_pc = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_any = 1'b1;
                winner    = SRC_W'(i);
                winner_pc = redir_pc[i*XLEN +: XLEN];
            end
        end
    end

    assign target_misaligned = |(winner_pc & OFFSET_MASK);
    assign target_aligned    = winner_pc & ~OFFSET_MASK;

    // The offered PC comes straight from registers, so fetch never sees a
    // combinational path from the redirect or halt inputs.
    assign req_valid = (state_q == ST_RUN);
    assign req_pc    = pc_q;
    assign handshake = req_valid & req_ready;

    // Next-state logic: redirect beats halt, halt beats sequential advance.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        misalign_pend_d = misalign_pend_q;
        if (redir_any) begin
            pc_d = target_aligned;
            if (target_misaligned) begin
                state_d         = ST_HALT;
                misalign_pend_d = 1'b1;
            end else begin
                state_d         = ST_RUN;
                misalign_pend_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (handshake) begin
                        pc_d = pc_q + PC_INC;
                    end
                    if (halt) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!halt && !misalign_pend_q) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // Architectural state: FSM, fetch PC and the sticky misalign-halt flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_PC;
            misalign_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            misalign_pend_q <= misalign_pend_d;
        end
    end

    // Registered single-cycle notifications telling fetch to flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redir_taken <= 1'b0;
            redir_src   <= '0;
            misalign    <= 1'b0;
        end else begin
            redir_taken <= redir_any;
            redir_src   <= winner;
            misalign    <= redir_any & target_misaligned;
        end
    end

endmodule

// File: tb/tb_pc_generator.sv
// tb_pc_generator: directed scenarios with fixed expected values, followed
// by a randomized run compared against a behavioural model of the fetch PC.
module tb_pc_generator;

    localparam int XLEN       = 64;
    localparam int NREDIR     = 3;
    localparam int INST_BYTES = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic                   clk;
    logic                   resetn;
    logic [NREDIR-1:0]      redir_valid;
    logic [NREDIR*XLEN-1:0] redir_pc;
    logic                   halt;
    logic                   req_valid;
    logic                   req_ready;
    logic [XLEN-1:0]        req_pc;
    logic                   redir_taken;
    logic [1:0]             redir_src;
    logic                   misalign;

    int n_vec;
    int n_err;

    // Behavioural model: fetch mode flags, PC and last-cycle notifications.
    bit          m_boot;
    bit          m_halted;
    bit          m_pend;
    logic [63:0] m_pc;
    bit          m_taken;
    int          m_src;
    bit          m_mis;

    pc_generator #(
        .XLEN(XLEN), .NREDIR(NREDIR), .RESET_PC(RESET_PC), .INST_BYTES(INST_BYTES)
    ) dut (
        .clk(clk), .resetn(resetn), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .halt(halt), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .redir_taken(redir_taken), .redir_src(redir_src), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic [2:0] v, input logic [63:0] p0,
                              input logic [63:0] p1, input logic [63:0] p2,
                              input logic h, input logic rdy);
        redir_valid = v;
        redir_pc    = {p2, p1, p0};
        halt        = h;
        req_ready   = rdy;
    endtask

    task automatic model_reset();
        m_boot = 1; m_halted = 0; m_pend = 0; m_pc = RESET_PC;
        m_taken = 0; m_src = 0; m_mis = 0;
    endtask

    // Advance one clock; the model is updated from the inputs seen at the edge.
    task automatic tick();
        bit running, any, nb, nh, np, nm;
        int w;
        logic [63:0] tgt, npc;
        running = !m_boot && !m_halted;
        any = 0; w = 0;
        for (int i = 0; i < NREDIR; i++) begin
            if (redir_valid[i] && !any) begin any = 1; w = i; end
        end
        nb = 0; nh = m_halted; np = m_pend; npc = m_pc; nm = 0;
        if (any) begin
            tgt = redir_pc[w*XLEN +: XLEN];
            nm  = (tgt % INST_BYTES) != 0;
            npc = tgt - (tgt % INST_BYTES);
            nh  = nm;
            np  = nm;
        end else if (m_boot) begin
            nh = 0;
        end else if (running) begin
            if (req_ready) npc = m_pc + INST_BYTES;
            if (halt) nh = 1;
        end else if (!halt && !m_pend) begin
            nh = 0;
        end
        @(posedge clk);
        m_boot = nb; m_halted = nh; m_pend = np; m_pc = npc;
        m_taken = any; m_src = w; m_mis = nm;
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL boot_valid got %b exp 0", req_valid); end
        n_vec++; if (req_pc !== RESET_PC) begin n_err++; $display("[TB] FAIL boot_pc got %h exp %h", req_pc, RESET_PC); end
        n_vec++; if (redir_taken !== 1'b0) begin n_err++; $display("[TB] FAIL reset_taken got %b exp 0", redir_taken); end
        n_vec++; if (redir_src !== 2'd0) begin n_err++; $display("[TB] FAIL reset_src got %0d exp 0", redir_src); end
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("[TB] FAIL reset_misalign got %b exp 0", misalign); end
    endtask

    task automatic test_sequential();
        logic [63:0] exp_pc;
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_pc = 64'h8000_0000 + 64'(4 * k);
            n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL seq_valid[%0d] got %b exp 1", k, req_valid); end
            n_vec++; if (req_pc !== exp_pc) begin n_err++; $display("[TB] FAIL seq_pc[%0d] got %h exp %h", k, req_pc, exp_pc); end
        end
        req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stall_valid[%0d] got %b exp 1", k, req_valid); end
            n_vec++; if (req_pc !== 64'h8000_0010) begin n_err++; $display("[TB] FAIL stall_pc[%0d] got %h exp 80000010", k, req_pc); end
        end
        req_ready = 1'b1;
        tick();
        n_vec++; if (req_pc !== 64'h8000_0014) begin n_err++; $display("[TB] FAIL stall_release_pc got %h exp 80000014", req_pc); end
    endtask

    task automatic test_redirect_priority();
        set_inputs(3'b110, 64'h0, 64'h1000, 64'h2000, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'h1000) begin n_err++; $display("[TB] FAIL prio_pc got %h exp 1000", req_pc); end
        n_vec++; if (redir_taken !== 1'b1) begin n_err++; $display("[TB] FAIL prio_taken got %b exp 1", redir_taken); end
        n_vec++; if (redir_src !== 2'd1) begin n_err++; $display("[TB] FAIL prio_src got %0d exp 1", redir_src); end
        n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL prio_valid got %b exp 1", req_valid); end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (redir_taken !== 1'b0) begin n_err++; $display("[TB] FAIL prio_pulse_end got %b exp 0", redir_taken); end
        n_vec++; if (req_pc !== 64'h1004) begin n_err++; $display("[TB] FAIL prio_next_pc got %h exp 1004", req_pc); end
    endtask

    task automatic test_misalign();
        set_inputs(3'b001, 64'h3002, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'h3000) begin n_err++; $display("[TB] FAIL mis_pc got %h exp 3000", req_pc); end
        n_vec++; if (misalign !== 1'b1) begin n_err++; $display("[TB] FAIL mis_pulse got %b exp 1", misalign); end
        n_vec++; if (redir_taken !== 1'b1) begin n_err++; $display("[TB] FAIL mis_taken got %b exp 1", redir_taken); end
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mis_valid got %b exp 0", req_valid); end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mis_hold_valid[%0d] got %b exp 0", k, req_valid); end
            n_vec++; if (misalign !== 1'b0) begin n_err++; $display("[TB] FAIL mis_pulse_end[%0d] got %b exp 0", k, misalign); end
            n_vec++; if (req_pc !== 64'h3000) begin n_err++; $display("[TB] FAIL mis_hold_pc[%0d] got %h exp 3000", k, req_pc); end
        end
        set_inputs(3'b100, 64'h0, 64'h0, 64'h4000, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mis_clear_valid got %b exp 1", req_valid); end
        n_vec++; if (req_pc !== 64'h4000) begin n_err++; $display("[TB] FAIL mis_clear_pc got %h exp 4000", req_pc); end
        n_vec++; if (redir_src !== 2'd2) begin n_err++; $display("[TB] FAIL mis_clear_src got %0d exp 2", redir_src); end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'h4004) begin n_err++; $display("[TB] FAIL mis_resume_pc got %h exp 4004", req_pc); end
    endtask

    task automatic test_halt();
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_valid[%0d] got %b exp 0", k, req_valid); end
            n_vec++; if (req_pc !== 64'h4008) begin n_err++; $display("[TB] FAIL halt_pc[%0d] got %h exp 4008", k, req_pc); end
        end
        set_inputs(3'b010, 64'h0, 64'h5000, 64'h0, 1'b1, 1'b1);
        tick();
        n_vec++; if (req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL halt_redir_valid got %b exp 1", req_valid); end
        n_vec++; if (req_pc !== 64'h5000) begin n_err++; $display("[TB] FAIL halt_redir_pc got %h exp 5000", req_pc); end
        n_vec++; if (redir_src !== 2'd1) begin n_err++; $display("[TB] FAIL halt_redir_src got %0d exp 1", redir_src); end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'h5004) begin n_err++; $display("[TB] FAIL halt_resume_pc got %h exp 5004", req_pc); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  vals [3];
        logic [63:0] exp_pc [3];
        logic [1:0]  exp_src [3];
        vals[0] = 3'b100; exp_pc[0] = 64'h6000; exp_src[0] = 2'd2;
        vals[1] = 3'b011; exp_pc[1] = 64'h7000; exp_src[1] = 2'd0;
        vals[2] = 3'b010; exp_pc[2] = 64'h7200; exp_src[2] = 2'd1;
        for (int k = 0; k < 3; k++) begin
            set_inputs(vals[k], 64'h7000, (k == 2) ? 64'h7200 : 64'h7100, 64'h6000, 1'b0, 1'b1);
            tick();
            n_vec++; if (redir_taken !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_taken[%0d] got %b exp 1", k, redir_taken); end
            n_vec++; if (req_pc !== exp_pc[k]) begin n_err++; $display("[TB] FAIL b2b_pc[%0d] got %h exp %h", k, req_pc, exp_pc[k]); end
            n_vec++; if (redir_src !== exp_src[k]) begin n_err++; $display("[TB] FAIL b2b_src[%0d] got %0d exp %0d", k, redir_src, exp_src[k]); end
        end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (redir_taken !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_end_taken got %b exp 0", redir_taken); end
        n_vec++; if (req_pc !== 64'h7204) begin n_err++; $display("[TB] FAIL b2b_end_pc got %h exp 7204", req_pc); end
    endtask

    task automatic test_wrap_and_reset();
        set_inputs(3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("[TB] FAIL wrap_top_pc got %h exp fffffffffffffffc", req_pc); end
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        tick();
        n_vec++; if (req_pc !== 64'h0) begin n_err++; $display("[TB] FAIL wrap_zero_pc got %h exp 0", req_pc); end
        tick();
        n_vec++; if (req_pc !== 64'h4) begin n_err++; $display("[TB] FAIL wrap_four_pc got %h exp 4", req_pc); end
        resetn = 1'b0;
        model_reset();
        #1;
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL async_rst_valid got %b exp 0", req_valid); end
        n_vec++; if (req_pc !== RESET_PC) begin n_err++; $display("[TB] FAIL async_rst_pc got %h exp %h", req_pc, RESET_PC); end
        @(negedge clk);
        resetn = 1'b1;
        n_vec++; if (req_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_boot_valid got %b exp 0", req_valid); end
        tick();
        n_vec++; if (req_pc !== RESET_PC || req_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rst_restart got pc %h valid %b exp pc %h valid 1", req_pc, req_valid, RESET_PC); end
    endtask

    task automatic test_random();
        logic [63:0] tgt [3];
        logic [2:0]  v;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            for (int i = 0; i < 3; i++) begin
                tgt[i] = {$urandom(), $urandom()};
                if ($urandom_range(0, 3) != 0) tgt[i] = tgt[i] - (tgt[i] % INST_BYTES);
                v[i] = ($urandom_range(0, 7) == 0);
            end
            set_inputs(v, tgt[0], tgt[1], tgt[2], $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
            tick();
            n_vec++; if (req_valid !== (!m_boot && !m_halted)) begin n_err++; $display("[TB] FAIL rnd_valid[%0d] got %b exp %b", n, req_valid, !m_boot && !m_halted); end
            n_vec++; if (req_pc !== m_pc) begin n_err++; $display("[TB] FAIL rnd_pc[%0d] got %h exp %h", n, req_pc, m_pc); end
            n_vec++; if (redir_taken !== m_taken) begin n_err++; $display("[TB] FAIL rnd_taken[%0d] got %b exp %b", n, redir_taken, m_taken); end
            n_vec++; if (misalign !== m_mis) begin n_err++; $display("[TB] FAIL rnd_misalign[%0d] got %b exp %b", n, misalign, m_mis); end
            if (m_taken) begin
                n_vec++; if (redir_src !== 2'(m_src)) begin n_err++; $display("[TB] FAIL rnd_src[%0d] got %0d exp %0d", n, redir_src, m_src); end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        set_inputs(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        test_reset();
        test_sequential();
        test_redirect_priority();
        test_misalign();
        test_halt();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_generator.md
Name: pc_generator

Overview:
- Parametrised fetch-stage PC source. Successor to the single-branch two-way PC mux.
- Holds the architectural fetch PC in a register and issues it to the fetch unit over a valid/ready handshake.
- Arbitrates NREDIR prioritised redirect channels (e.g. exception/CSR, execute branch, decode jump). Supports halt and misaligned-target detection.

Parameters:
- XLEN, 64, width of PC and redirect targets.
- NREDIR, 3, number of redirect channels; channel 0 is highest priority.
- RESET_PC, 64'h8000_0000, first PC fetched after reset.
- INST_BYTES, 4, sequential increment; also the alignment requirement (power of two).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- redir_valid  in  NREDIR  per-channel redirect request.
- redir_pc  in  NREDIR*XLEN  per-channel target; channel i occupies bits [i*XLEN +: XLEN].
- halt  in  1  level request to stop issuing PCs.
- req_valid  out  1  req_pc is valid for fetch.
- req_ready  in  1  fetch accepts req_pc this cycle.
- req_pc  out  XLEN  PC offered to fetch.
- redir_taken  out  1  registered pulse: a redirect was applied last cycle, so fetch must drop in-flight work.
- redir_src  out  $clog2(NREDIR) (min 1)  index of the applied channel, valid with redir_taken.
- misalign  out  1  registered pulse: winning target was not INST_BYTES-aligned.

Behaviour:
- States: BOOT, RUN, HALT. Encoding is free.
- Reset (resetn=0, asynchronous):
  - state=BOOT, pc=RESET_PC.
  - req_valid=0, redir_taken=0, redir_src=0, misalign=0.
- BOOT: lasts exactly one cycle after reset release; req_valid=0; then goes to RUN. A redirect seen in BOOT is applied (pc replaced) before RUN.
- RUN:
  - req_valid=1 and req_pc=pc (direct from the register, no combinational path from inputs).
  - A handshake is req_valid & req_ready. On a handshake with no redirect, pc <= pc+INST_BYTES, wrapping modulo 2^XLEN.
- Redirect arbitration:
  - The winner is the lowest index i with redir_valid[i]=1.
  - A redirect overrides everything: pc <= redir_pc[winner] next cycle, whether or not a handshake occurred this cycle.
  - The offered PC on that cycle is considered flushed even if accepted. The valid/ready stability rule is waived on redirect: req_pc may change while req_valid is held.
  - On the next cycle: redir_taken=1, redir_src=winner.
- Misaligned target:
  - Condition: winner target has low log2(INST_BYTES) bits nonzero.
  - pc is loaded with the target with those low bits cleared; state goes to HALT; misalign pulses 1 for one cycle along with redir_taken.
- halt:
  - halt=1 in RUN with no redirect: state goes to HALT next cycle; pc advances only if a handshake occurred that cycle.
  - In HALT: req_valid=0 and pc is held.
  - Leave HALT to RUN when halt=0 and no misalign is pending, or on any aligned redirect, which wins even if halt=1.
  - An aligned redirect clears a misalign-induced HALT.
- Simultaneous events:
  - redirect > halt > sequential advance.
  - Multiple redir_valid: only the winner is applied; others are silently dropped.
- Reset mid-operation: immediately forces the reset values; the pending handshake is lost.
- Pulse outputs (redir_taken, misalign) are single-cycle and registered. Back-to-back redirects produce consecutive pulses.

Test Plan:
- Reset release, req_ready=1 constant -> cycle1 req_valid=0 (BOOT); then req_pc = 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles.
- req_ready=0 for 3 cycles in RUN at pc 0x8000_0010 -> req_pc holds 0x8000_0010 and req_valid stays 1; advances to 0x8000_0014 one cycle after ready rises.
- redir_valid=3'b110 with targets ch1=0x1000, ch2=0x2000 -> next cycle req_pc=0x1000, redir_taken=1, redir_src=1; following cycle redir_taken=0.
- Redirect ch0 to 0x3002 -> pc=0x3000, misalign=1, req_valid=0 (HALT); later aligned redirect ch2 to 0x4000 -> RUN, req_pc=0x4000.
- halt=1 for 2 cycles -> req_valid=0 and pc frozen; redirect ch1 to 0x5000 while halt=1 -> RUN at 0x5000.
- pc=0xFFFF_FFFF_FFFF_FFFC with a handshake -> wraps to 0x0; assert resetn=0 mid-stream -> req_valid drops asynchronously, pc restarts at RESET_PC.
